seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_pkg.sv | 26 ++
 rtl/seq_divider_div_step.sv | 20 ++
 rtl/seq_divider.sv | 97 +++++++++
 tb/tb_seq_divider.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: operand widths, step count,
// FSM state encoding and the dividend bit-order helper.
package seq_divider_pkg;

    localparam int unsigned DIVIDEND_W = 8;
    localparam int unsigned DIVISOR_W  = 4;
    localparam int unsigned REM_W      = DIVISOR_W + 1;
    localparam int unsigned STEPS      = 8;
    localparam int unsigned STEP_CNT_W = $clog2(STEPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // The x register delivers the dividend LSB-first on the bus; restore natural order.
    function automatic logic [DIVIDEND_W-1:0] bit_reverse(input logic [DIVIDEND_W-1:0] x);
        logic [DIVIDEND_W-1:0] r;
        for (int i = 0; i < DIVIDEND_W; i++) begin
            r[i] = x[DIVIDEND_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: trial-subtract the divisor from the
// already-shifted partial remainder and emit the resulting quotient bit.
module div_step
    import seq_divider_pkg::*;
(
    input  logic [REM_W-1:0]     partial_rem,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [REM_W-1:0]     rem_next,
    output logic                 q_bit
);

    logic [REM_W-1:0] divisor_ext;

    always_comb begin
        divisor_ext = REM_W'(divisor);
        q_bit       = (partial_rem >= divisor_ext);
        rem_next    = q_bit ? (partial_rem - divisor_ext) : partial_rem;
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential 8-bit / 4-bit unsigned restoring divider, one quotient bit per cycle,
// with an immediate divide-by-zero path.
module seq_divider
    import seq_divider_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend_in,
    input  logic [DIVISOR_W-1:0]  divisor_in,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  busy,
    output logic                  done,
    output logic                  dz_err
);

    state_e                  state;
    logic [DIVIDEND_W-1:0]   dvd_q;
    logic [DIVISOR_W-1:0]    dsr_q;
    logic [REM_W-1:0]        rem_q;
    logic [STEP_CNT_W-1:0]   step_q;
    logic [REM_W-1:0]        partial_rem;
    logic [REM_W-1:0]        rem_next;
    logic                    q_bit;

    // Shift the partial remainder left, bringing in the next dividend bit (MSB first).
    assign partial_rem = REM_W'({rem_q, dvd_q[DIVIDEND_W-1]});

    div_step u_div_step (
        .partial_rem (partial_rem),
        .divisor     (dsr_q),
        .rem_next    (rem_next),
        .q_bit       (q_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            dvd_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            step_q    <= '0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dz_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor_in != '0) begin
                            dvd_q     <= bit_reverse(dividend_in);
                            dsr_q     <= divisor_in;
                            rem_q     <= '0;
                            step_q    <= '0;
                            quotient  <= '0;
                            remainder <= '0;
                            dz_err    <= 1'b0;
                            busy      <= 1'b1;
                            state     <= RUN;
                        end else begin
                            quotient  <= '1;
                            remainder <= '0;
                            dz_err    <= 1'b1;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                RUN: begin
                    dvd_q    <= dvd_q << 1;
                    rem_q    <= rem_next;
                    quotient <= {quotient[DIVIDEND_W-2:0], q_bit};
                    step_q   <= step_q + 1'b1;
                    if (step_q == STEP_CNT_W'(STEPS - 1)) begin
                        remainder <= rem_next[DIVISOR_W-1:0];
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus random divisions
// compared against plain integer division of the un-reversed dividend.
module tb_seq_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend_in;
    logic [3:0] divisor_in;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       dz_err;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    seq_divider dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend_in (dividend_in),
        .divisor_in  (divisor_in),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .dz_err      (dz_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: bus carries the dividend bit-reversed; result is plain integer division.
    function automatic int unsigned model_dividend(input logic [7:0] din);
        int unsigned v = 0;
        for (int i = 0; i < 8; i++) if (din[i]) v += (1 << (7 - i));
        return v;
    endfunction

    // Issue one division, measure latency, compare against the model.
    task automatic run_div(input logic [7:0] din, input logic [3:0] dsr, input string tag);
        int unsigned dvd, exp_q, exp_r, exp_lat;
        int cycles;
        dvd     = model_dividend(din);
        exp_q   = (dsr == 0) ? 32'hFF : dvd / dsr;
        exp_r   = (dsr == 0) ? 0 : dvd % dsr;
        exp_lat = (dsr == 0) ? 0 : 8;
        @(negedge clk);
        dividend_in = din;
        divisor_in  = dsr;
        start       = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
        dividend_in = 8'($urandom);
        divisor_in  = 4'($urandom);
        cycles = 0;
        while (done !== 1'b1 && cycles < 20) begin
            if (busy !== 1'b1) break;
            @(posedge clk); #1;
            cycles++;
        end
        check({tag, "_latency"}, 32'(cycles), exp_lat);
        check({tag, "_q"}, 32'(quotient), exp_q);
        check({tag, "_r"}, 32'(remainder), exp_r);
        check({tag, "_dz"}, 32'(dz_err), 32'(dsr == 0));
        check({tag, "_busy_in_done"}, 32'(busy), 0);
        @(posedge clk); #1;
        check({tag, "_done_one_cycle"}, 32'(done), 0);
        check({tag, "_q_hold"}, 32'(quotient), exp_q);
    endtask

    initial begin
        int base;
        rst = 1'b0; start = 1'b0; dividend_in = '0; divisor_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_q", 32'(quotient), 0);
        check("reset_r", 32'(remainder), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_dz", 32'(dz_err), 0);

        // Reset wins over start in the same cycle.
        @(negedge clk); start = 1'b1; dividend_in = 8'h26; divisor_in = 4'd7;
        @(posedge clk); #1;
        check("rst_prio_busy", 32'(busy), 0);
        check("rst_prio_done", 32'(done), 0);
        start = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        check("rst_prio_no_queue", 32'(busy), 0);

        run_div(8'h26, 4'd7, "d100_7");
        check("d100_7_lit_q", 32'(quotient), 32'h0E);
        check("d100_7_lit_r", 32'(remainder), 32'h2);
        run_div(8'hFF, 4'd1, "d255_1");
        check("d255_1_lit_q", 32'(quotient), 32'hFF);
        run_div(8'hA0, 4'd9, "d5_9");
        check("d5_9_lit_r", 32'(remainder), 32'h5);
        run_div(8'hAA, 4'd0, "d55_0");
        check("d55_0_lit_dz", 32'(dz_err), 1);
        run_div(8'hFF, 4'd15, "d255_15");

        // Start re-pulsed mid-RUN must be ignored.
        base = done_cnt;
        @(negedge clk); start = 1'b1; dividend_in = 8'h26; divisor_in = 4'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); start = 1'b1; dividend_in = 8'hFF; divisor_in = 4'd1;
        @(posedge clk); #1; start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("repulse_q", 32'(quotient), 32'h0E);
        check("repulse_r", 32'(remainder), 32'h2);
        check("repulse_done_count", 32'(done_cnt - base), 1);

        // Reset mid-RUN aborts with no done pulse.
        base = done_cnt;
        @(negedge clk); start = 1'b1; dividend_in = 8'h26; divisor_in = 4'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        check("abort_q", 32'(quotient), 0);
        check("abort_r", 32'(remainder), 0);
        check("abort_busy", 32'(busy), 0);
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt - base), 0);
        run_div(8'h26, 4'd7, "after_abort");
        check("after_abort_lit_q", 32'(quotient), 32'd14);

        for (int i = 0; i < 20; i++) begin
            run_div(8'($urandom), 4'($urandom_range(0, 15)), $sformatf("rand%0d", i));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
